// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a spike train back into numbers.
//   - Counts spikes over a programmable window and offers the count on a
//     registered valid/ready interface (rate_out/rate_valid/rate_ready).
//   - Flags a dropped window result in a sticky overrun bit.
//   - Measures the inter-spike interval of consecutive spikes (isi_out/isi_valid).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : decoding active when high
//   spike             : spike train, sampled every rising edge
//   window            : window length in cycles (0 behaves as 1)
//   rate_out/_valid   : count of the last completed window, handshake valid
//   rate_ready        : consumer accepts rate_out when high with rate_valid
//   overrun           : sticky, a window result was dropped
//   clear_overrun     : synchronous clear of overrun (a same-edge set wins)
//   isi_out/isi_valid : cycles between the last two spikes, one-cycle pulse
module spike_rate_decoder #(
  parameter int unsigned WINDOW_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                spike,
  input  logic [WINDOW_W-1:0] window,
  output logic [7:0]          rate_out,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overrun,
  input  logic                clear_overrun,
  output logic [7:0]          isi_out,
  output logic                isi_valid
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
  localparam logic [CNT_W-1:0] ISI_MAX = 8'hFE;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t              state_q,    state_d;
  logic [WINDOW_W-1:0] win_len_q,  win_len_d;
  logic [WINDOW_W-1:0] win_cnt_q,  win_cnt_d;
  logic [CNT_W-1:0]    spk_cnt_q,  spk_cnt_d;
  logic [CNT_W-1:0]    isi_cnt_q,  isi_cnt_d;
  logic                seen_q,     seen_d;
  logic [CNT_W-1:0]    rate_q,     rate_d;
  logic                rvalid_q,   rvalid_d;
  logic                ovr_q,      ovr_d;
  logic [CNT_W-1:0]    isi_q,      isi_d;
  logic                isiv_q,     isiv_d;

  // Window length as used by the datapath: a programmed 0 means 1.
  logic [WINDOW_W-1:0] window_eff;
  // Counter views for this edge; entering COUNT starts from zero so the
  // entry edge is the first counted edge of the first window.
  logic [WINDOW_W-1:0] win_base, len_base;
  logic [CNT_W-1:0]    spk_base, isi_base, final_cnt;
  logic                seen_base;
  logic                win_end;

  assign window_eff = (window == '0) ? WINDOW_W'(1) : window;

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    win_cnt_d = win_cnt_q;
    spk_cnt_d = spk_cnt_q;
    isi_cnt_d = isi_cnt_q;
    seen_d    = seen_q;
    rate_d    = rate_q;
    rvalid_d  = rvalid_q;
    ovr_d     = ovr_q;
    isi_d     = isi_q;
    isiv_d    = 1'b0;
    win_end   = 1'b0;

    if (state_q == S_IDLE) begin
      win_base  = '0;
      len_base  = window_eff;
      spk_base  = '0;
      isi_base  = '0;
      seen_base = 1'b0;
    end else begin
      win_base  = win_cnt_q;
      len_base  = win_len_q;
      spk_base  = spk_cnt_q;
      isi_base  = isi_cnt_q;
      seen_base = seen_q;
    end

    // Saturating count including this edge's spike.
    final_cnt = (spike && (spk_base != CNT_MAX)) ? CNT_W'(spk_base + 8'd1) : spk_base;

    if (enable) begin
      state_d = S_COUNT;

      // Window progress; the new window length is sampled only at a window start.
      if (win_base == WINDOW_W'(len_base - WINDOW_W'(1))) begin
        win_end   = 1'b1;
        win_cnt_d = '0;
        spk_cnt_d = '0;
        win_len_d = window_eff;
      end else begin
        win_cnt_d = WINDOW_W'(win_base + WINDOW_W'(1));
        spk_cnt_d = final_cnt;
        win_len_d = len_base;
      end

      // Inter-spike interval; the first spike only arms the measurement.
      if (spike) begin
        if (seen_base) begin
          isi_d  = (isi_base == CNT_MAX) ? CNT_MAX : CNT_W'(isi_base + 8'd1);
          isiv_d = 1'b1;
        end
        isi_cnt_d = '0;
        seen_d    = 1'b1;
      end else begin
        isi_cnt_d = (isi_base >= ISI_MAX) ? ISI_MAX : CNT_W'(isi_base + 8'd1);
        seen_d    = seen_base;
      end
    end else begin
      // Leaving or staying in IDLE: partial window and ISI history are dropped.
      state_d   = S_IDLE;
      win_cnt_d = '0;
      spk_cnt_d = '0;
      isi_cnt_d = '0;
      seen_d    = 1'b0;
    end

    // Result delivery; acceptance on the same edge frees the slot for the new result.
    if (win_end) begin
      if (!rvalid_q || rate_ready) begin
        rate_d   = final_cnt;
        rvalid_d = 1'b1;
      end else begin
        ovr_d    = 1'b1;
      end
    end else if (rvalid_q && rate_ready) begin
      rvalid_d = 1'b0;
    end

    // Clear only when nothing sets overrun on this edge.
    if (clear_overrun && !(win_end && rvalid_q && !rate_ready)) begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      win_len_q <= WINDOW_W'(1);
      win_cnt_q <= '0;
      spk_cnt_q <= '0;
      isi_cnt_q <= '0;
      seen_q    <= 1'b0;
      rate_q    <= '0;
      rvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
      isi_q     <= '0;
      isiv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_len_q <= win_len_d;
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      isi_cnt_q <= isi_cnt_d;
      seen_q    <= seen_d;
      rate_q    <= rate_d;
      rvalid_q  <= rvalid_d;
      ovr_q     <= ovr_d;
      isi_q     <= isi_d;
      isiv_q    <= isiv_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = rvalid_q;
  assign overrun    = ovr_q;
  assign isi_out    = isi_q;
  assign isi_valid  = isiv_q;

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Output-side decoder for the LIF neuron's spike train. It counts spikes over a programmable window of clock cycles and presents the count as an 8-bit firing rate through a valid/ready handshake. It also measures the inter-spike interval (ISI) of consecutive spikes. It sits downstream of a neuron's `spike` output and turns the spike domain back into numeric values for readout or for the next stage.

## Interface
- `WINDOW_W`, default 10: width of the window-length input; windows span 1 to 2^WINDOW_W−1 cycles.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: decoding active when high.
- `spike`, input, 1: spike train, sampled every cycle.
- `window`, input, WINDOW_W: window length in cycles; 0 is treated as 1.
- `rate_out`, output, 8: spike count of the last completed window.
- `rate_valid`, output, 1: `rate_out` holds an unconsumed result.
- `rate_ready`, input, 1: consumer accepts `rate_out` when high together with `rate_valid`.
- `overrun`, output, 1: sticky flag; a window result was dropped.
- `clear_overrun`, input, 1: synchronous clear of `overrun`.
- `isi_out`, output, 8: cycles between the last two spikes, saturated at 255.
- `isi_valid`, output, 1: one-cycle pulse when `isi_out` updates.

## Operation
- **Reset values:** `rate_out`=0, `rate_valid`=0, `overrun`=0, `isi_out`=0, `isi_valid`=0. Reset also clears all internal counters, `seen_spike` and the FSM (IDLE). Reset asserted mid-window discards the partial window.
- **FSM states:**
  - IDLE: `enable`=0.
  - COUNT: window in progress.
- **IDLE → COUNT:** on the first sampled edge with `enable`=1.
  - Latch `win_len` = max(`window`,1).
  - Set `win_cnt`=0 and `spk_cnt`=0. The spike sampled on that same edge is counted.
- **COUNT behaviour, per edge:**
  - `spk_cnt` increments by `spike`, saturating at 255.
  - `win_cnt` increments.
  - When `win_cnt` = `win_len`−1, that edge ends the window.
- **Window end:**
  - The final count includes that edge's spike.
  - Set `win_cnt`=0 and `spk_cnt`=0.
  - Relatch `win_len` from `window`. Changes to `window` mid-window take effect only at the next window start.
- **Result delivery at window end:**
  - If `rate_valid`=0, or `rate_valid`=1 and `rate_ready`=1 on the same edge: load `rate_out` with the final count and set `rate_valid`=1.
  - Otherwise: drop the new result, keep `rate_out` unchanged, set `overrun`=1.
- **Handshake:**
  - `rate_valid`&`rate_ready` on an edge with no window end clears `rate_valid`.
  - `rate_out` is stable while `rate_valid`=1.
- **Overrun flag:**
  - `clear_overrun` clears `overrun`.
  - If a set and a clear occur on the same edge, set wins.
- **COUNT → IDLE:** on an edge with `enable`=0.
  - The partial window is discarded and spikes are ignored.
  - A pending `rate_out`/`rate_valid` is retained and can still be accepted in IDLE.
- **ISI measurement (COUNT only):**
  - `isi_cnt` counts cycles since the last spike: 8-bit, saturating at 254, cleared to 0 on a spike, held in IDLE.
  - On a spike with `seen_spike`=1: `isi_out` ← min(`isi_cnt`+1, 255) and `isi_valid` pulses.
  - The first spike after entering COUNT only sets `seen_spike`; there is no `isi_valid`.
  - Leaving COUNT clears `seen_spike` and `isi_cnt`.
- **Arithmetic:** all counters are unsigned. Nothing wraps; overflow always saturates.

## Timing
- The spike sampled at edge N is counted at edge N.
- For a window ending at edge N, `rate_valid` and `rate_out` are visible after edge N: one cycle of latency from the last sampled spike.
- `isi_valid` is high for exactly the cycle after the edge that sampled the closing spike. Consecutive-cycle spikes give `isi_out`=1 and back-to-back `isi_valid` pulses.
- Back-to-back windows have no dead cycle. With `window`=1, every edge ends a window.
- `rate_ready` is combinationally unused; all acceptance is registered. There is no `rate_ready` → `rate_valid` combinational path.

## Test plan
- Reset, then `enable`=1, `window`=10, `spike` high on 3 cycles of the window, `rate_ready`=1 → `rate_valid` high for 1 cycle after the 10th edge with `rate_out`=3; next window spike-free → `rate_out`=0.
- `window`=400, `spike` held high → `rate_out`=255 (saturated); `overrun` stays 0 because `rate_ready`=1.
- `window`=4, `rate_ready`=0 for 3 windows → first result held with `rate_valid`=1, `overrun`=1 after the 2nd window end; then `clear_overrun` → 0. Separately, `rate_ready` asserted exactly on a window-end edge → new value loaded, `rate_valid` stays 1, no `overrun`.
- Spikes at edges 5, 6 and 20 after enable → no `isi_valid` at 5; `isi_out`=1 at 6; `isi_out`=14 at 20. A 300-cycle gap → `isi_out`=255.
- `enable` dropped at cycle 5 of a 10-cycle window with a pending unaccepted result → partial count discarded, `rate_out` retained and accepted later; re-enable restarts at `win_cnt`=0 with no `isi_valid` on the first spike.
- Async `reset` pulsed mid-cycle during COUNT with `rate_valid`=1 → all outputs 0 immediately, without waiting for a clock edge.
